// File: rtl/ctc_param_if.sv
// Serial instruction input, key matrix and status outputs of the ctc_param block.
interface ctc_param_if #(
  parameter int KR_W = 8,
  parameter int KC_W = 5
);
  logic            is;
  logic [KC_W-1:0] kc;
  logic            sync;
  logic            ws;
  logic [KR_W-1:0] kr;
  logic [3:0]      ptr;
  logic            kflag;
  logic [7:0]      kcode;

  modport master (
    output is, kc,
    input  sync, ws, kr, ptr, kflag, kcode
  );

  modport slave (
    input  is, kc,
    output sync, ws, kr, ptr, kflag, kcode
  );
endinterface

// File: rtl/ctc_param.sv
// Control and timing block: word timing, serial instruction decode, pointer, ws gate, key scan.
// Define CTC_KEY_DEBOUNCE_EN to require the same key candidate in two consecutive words.
module ctc_param #(
  parameter int NDIGIT = 14,
  parameter int KR_W   = 8,
  parameter int KC_W   = 5
) (
  input  logic        cph2,
  input  logic        pon,
  ctc_param_if.slave  bus
);

  localparam int       W     = 4 * NDIGIT;
  localparam logic [5:0] LAST  = 6'(W - 1);
  localparam logic [5:0] SYNC0 = 6'(W - 10);
  localparam logic [3:0] PMAX  = 4'(NDIGIT - 1);
  localparam logic [3:0] RLAST = 4'(KR_W - 1);

  typedef enum logic [1:0] {
    WS_OFF,
    WS_P,
    WS_WP,
    WS_WORD
  } ws_mode_t;

  logic [5:0]      cnt;
  logic            sync_r;
  logic [8:0]      sbuf;
  logic [9:0]      ir;
  ws_mode_t        mode;
  logic [3:0]      ptr;
  logic [3:0]      row;
  logic [KR_W-1:0] kr;
  logic            kflag;
  logic [7:0]      kcode;
  logic            lockout;
  logic            cand_v;
  logic [7:0]      cand;

  logic            wend;
  logic            hit;
  logic [3:0]      col;
  logic            take;
  logic            word_v;
  logic [7:0]      word_c;
  logic [9:0]      ir_next;
  logic            op_clear;
  logic            kflag_eff;
  logic            qualified;
  logic            key_evt;
  logic [3:0]      ptr_next;
  logic            ws_c;

  function automatic ws_mode_t decode_mode(input logic [9:0] v);
    ws_mode_t m;
    m = WS_OFF;
    if (v[1:0] == 2'b10) begin
      case (v[4:2])
        3'b000:  m = WS_P;
        3'b001:  m = WS_WP;
        3'b111:  m = WS_WORD;
        default: m = WS_OFF;
      endcase
    end
    return m;
  endfunction

  always_comb begin
    col = '0;
    for (int unsigned i = KC_W; i > 0; i--) begin
      if (bus.kc[i-1]) col = 4'(i - 1);
    end
  end

  // The sample taken on the word-end edge still belongs to the word being closed.
  always_comb begin
    wend      = (cnt == LAST);
    hit       = |bus.kc;
    take      = hit && (!cand_v || (row < cand[3:0]));
    word_v    = cand_v || hit;
    word_c    = take ? {col, row} : cand;
    ir_next   = {bus.is, sbuf};
    op_clear  = (ir == '0);
    kflag_eff = kflag && !op_clear;
    key_evt   = word_v && qualified && !kflag_eff && !lockout;
  end

  always_comb begin
    ptr_next = ptr;
    if (ir[1:0] == 2'b00) begin
      case (ir[3:2])
        2'b11:   ptr_next = (ir[9:6] > PMAX) ? PMAX : ir[9:6];
        2'b01:   ptr_next = (ptr == PMAX) ? '0 : ptr + 4'd1;
        2'b10:   ptr_next = (ptr == '0) ? PMAX : ptr - 4'd1;
        default: ptr_next = ptr;
      endcase
    end
  end

`ifdef CTC_KEY_DEBOUNCE_EN
  logic       deb_v;
  logic [7:0] deb;

  assign qualified = deb_v && (deb == word_c);

  always_ff @(posedge cph2 or posedge pon) begin
    if (pon) begin
      deb_v <= 1'b0;
      deb   <= '0;
    end else if (wend) begin
      deb_v <= word_v;
      deb   <= word_c;
    end
  end
`else
  assign qualified = 1'b1;
`endif

  always_ff @(posedge cph2 or posedge pon) begin
    if (pon) begin
      cnt     <= '0;
      sync_r  <= 1'b0;
      sbuf    <= '0;
      ir      <= '0;
      mode    <= WS_OFF;
      ptr     <= '0;
      row     <= '0;
      kr      <= {{(KR_W-1){1'b0}}, 1'b1};
      kflag   <= 1'b0;
      kcode   <= '0;
      lockout <= 1'b0;
      cand_v  <= 1'b0;
      cand    <= '0;
    end else begin
      cnt    <= wend ? '0 : cnt + 6'd1;
      sync_r <= !wend && ((cnt + 6'd1) >= SYNC0);
      if (sync_r) sbuf <= ir_next[9:1];

      if (wend || (row == RLAST)) begin
        row <= '0;
        kr  <= {{(KR_W-1){1'b0}}, 1'b1};
      end else begin
        row <= row + 4'd1;
        kr  <= {kr[KR_W-2:0], 1'b0};
      end

      if (wend) begin
        ir      <= ir_next;
        mode    <= decode_mode(ir_next);
        ptr     <= ptr_next;
        kflag   <= kflag_eff || key_evt;
        if (key_evt) kcode <= word_c;
        lockout <= word_v && (lockout || key_evt);
        cand_v  <= 1'b0;
      end else if (take) begin
        cand_v <= 1'b1;
        cand   <= {col, row};
      end
    end
  end

  always_comb begin
    case (mode)
      WS_P:    ws_c = (cnt[5:2] == ptr);
      WS_WP:   ws_c = (cnt[5:2] <= ptr);
      WS_WORD: ws_c = 1'b1;
      default: ws_c = 1'b0;
    endcase
  end

  assign bus.ws    = ws_c;
  assign bus.sync  = sync_r;
  assign bus.kr    = kr;
  assign bus.ptr   = ptr;
  assign bus.kflag = kflag;
  assign bus.kcode = kcode;

endmodule
